// File: rtl/bullet_pkg.sv
// Shared types and constants for the enemy-bullet hit scheduling logic.
package bullet_pkg;

    localparam int unsigned COORD_W = 10;
    // One extra bit so coordinate + window extent never overflows.
    localparam int unsigned CMP_W   = 11;

    localparam int unsigned DEF_X_LO = 10;
    localparam int unsigned DEF_X_HI = 50;
    localparam int unsigned DEF_Y_LO = 50;
    localparam int unsigned DEF_Y_HI = 40;

    typedef enum logic [1:0] {
        StIdle,
        StScan,
        StApply
    } state_e;

endpackage

// File: rtl/hit_box_cmp.sv
// Registered single-stage hit-box comparator; result appears one cycle after presentation.
module hit_box_cmp
    import bullet_pkg::*;
#(
    parameter int unsigned X_LO  = DEF_X_LO,
    parameter int unsigned X_HI  = DEF_X_HI,
    parameter int unsigned Y_LO  = DEF_Y_LO,
    parameter int unsigned Y_HI  = DEF_Y_HI,
    parameter int unsigned IDX_W = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [COORD_W-1:0] px,
    input  logic [COORD_W-1:0] py,
    input  logic [COORD_W-1:0] ex,
    input  logic [COORD_W-1:0] ey,
    input  logic               valid_in,
    input  logic [IDX_W-1:0]   idx_in,
    output logic               hit_q,
    output logic               valid_q,
    output logic [IDX_W-1:0]   idx_q
);

    logic [CMP_W-1:0] px_w, py_w, ex_w, ey_w;
    logic             hit_d;

    // Window test with the extents added on the side that cannot underflow.
    always_comb begin
        px_w  = {1'b0, px};
        py_w  = {1'b0, py};
        ex_w  = {1'b0, ex};
        ey_w  = {1'b0, ey};
        hit_d = (px_w + CMP_W'(X_LO) >= ex_w) && (px_w < ex_w + CMP_W'(X_HI)) &&
                (py_w + CMP_W'(Y_LO) >= ey_w) && (py_w < ey_w + CMP_W'(Y_HI));
    end

    // Result register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            hit_q   <= 1'b0;
            valid_q <= 1'b0;
            idx_q   <= '0;
        end else begin
            hit_q   <= valid_in && hit_d;
            valid_q <= valid_in;
            idx_q   <= idx_in;
        end
    end

endmodule

// File: rtl/bullet_hit_scheduler.sv
// Frame-paced scan of enemy bullets against the player through one shared comparator.
module bullet_hit_scheduler
    import bullet_pkg::*;
#(
    parameter int unsigned N_EB          = 8,
    parameter int unsigned HP_INIT       = 3,
    parameter int unsigned IFRAME_FRAMES = 30,
    parameter int unsigned X_LO          = DEF_X_LO,
    parameter int unsigned X_HI          = DEF_X_HI,
    parameter int unsigned Y_LO          = DEF_Y_LO,
    parameter int unsigned Y_HI          = DEF_Y_HI
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    frame_tick,
    input  logic [COORD_W-1:0]      p_x,
    input  logic [COORD_W-1:0]      p_y,
    input  logic                    my_en,
    input  logic [COORD_W*N_EB-1:0] eb_x_flat,
    input  logic [COORD_W*N_EB-1:0] eb_y_flat,
    input  logic [N_EB-1:0]         eb_en,
    output logic [N_EB-1:0]         eb_clr,
    output logic [3:0]              present_health,
    output logic                    hit_pulse,
    output logic                    boom,
    output logic                    scan_busy,
    output logic                    frame_overrun
);

    localparam int unsigned IDX_W = $clog2(N_EB);
    // Counter reaches N_EB for the pipeline drain cycle.
    localparam int unsigned CNT_W = $clog2(N_EB + 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   idx_q;
    logic [COORD_W-1:0] px_q, py_q;
    logic               my_en_q;
    logic               hit_any_q;
    logic [3:0]         health_q;
    logic [7:0]         iframe_q;
    logic               hit_pulse_q;
    logic               boom_q;
    logic               overrun_q;

    logic               cmp_valid;
    logic [IDX_W-1:0]   cmp_idx;
    logic [COORD_W-1:0] ex_arr [N_EB];
    logic [COORD_W-1:0] ey_arr [N_EB];
    logic               res_hit, res_valid;
    logic [IDX_W-1:0]   res_idx;
    logic               clr_any;

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) state_q <= StIdle;
        else      state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (frame_tick) state_d = StScan;
            StScan:  if (idx_q == CNT_W'(N_EB)) state_d = StApply;
            StApply: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // FSM outputs: busy flag and the slot presented to the comparator.
    always_comb begin
        scan_busy = (state_q == StScan);
        cmp_valid = (state_q == StScan) && (idx_q < CNT_W'(N_EB));
        cmp_idx   = cmp_valid ? IDX_W'(idx_q) : '0;
    end

    // Unpack the flat bullet buses into per-slot coordinates.
    always_comb begin
        for (int i = 0; i < N_EB; i++) begin
            ex_arr[i] = eb_x_flat[COORD_W*i +: COORD_W];
            ey_arr[i] = eb_y_flat[COORD_W*i +: COORD_W];
        end
    end

    hit_box_cmp #(
        .X_LO  (X_LO),
        .X_HI  (X_HI),
        .Y_LO  (Y_LO),
        .Y_HI  (Y_HI),
        .IDX_W (IDX_W)
    ) u_cmp (
        .clk      (clk),
        .rst      (rst),
        .px       (px_q),
        .py       (py_q),
        .ex       (ex_arr[cmp_idx]),
        .ey       (ey_arr[cmp_idx]),
        .valid_in (cmp_valid),
        .idx_in   (cmp_idx),
        .hit_q    (res_hit),
        .valid_q  (res_valid),
        .idx_q    (res_idx)
    );

    // Clear decode for the slot whose result is on the comparator output.
    always_comb begin
        eb_clr = '0;
        if (rst && res_valid && res_hit && eb_en[res_idx] && my_en_q && (health_q != 4'd0)) begin
            eb_clr[res_idx] = 1'b1;
        end
        clr_any = |eb_clr;
    end

    // Frame datapath: latching, scan index, damage, invulnerability and sticky flags.
    always_ff @(posedge clk) begin
        if (!rst) begin
            idx_q       <= '0;
            px_q        <= '0;
            py_q        <= '0;
            my_en_q     <= 1'b0;
            hit_any_q   <= 1'b0;
            health_q    <= 4'(HP_INIT);
            iframe_q    <= '0;
            hit_pulse_q <= 1'b0;
            boom_q      <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            hit_pulse_q <= 1'b0;
            boom_q      <= boom_q | (health_q == 4'd0);
            // A tick is only accepted from idle; anything else is an overrun.
            if (frame_tick && (state_q != StIdle)) overrun_q <= 1'b1;
            unique case (state_q)
                StIdle: begin
                    if (frame_tick) begin
                        px_q      <= p_x;
                        py_q      <= p_y;
                        my_en_q   <= my_en;
                        hit_any_q <= 1'b0;
                        idx_q     <= '0;
                        if (iframe_q != 8'd0) iframe_q <= iframe_q - 8'd1;
                    end
                end
                StScan: begin
                    if (idx_q != CNT_W'(N_EB)) idx_q <= idx_q + CNT_W'(1);
                    if (clr_any) hit_any_q <= 1'b1;
                end
                StApply: begin
                    if (hit_any_q && (iframe_q == 8'd0) && (health_q != 4'd0)) begin
                        health_q    <= health_q - 4'd1;
                        hit_pulse_q <= 1'b1;
                        iframe_q    <= 8'(IFRAME_FRAMES);
                    end
                end
                default: ;
            endcase
        end
    end

    assign present_health = health_q;
    assign hit_pulse      = hit_pulse_q;
    assign boom           = boom_q;
    assign frame_overrun  = overrun_q;

endmodule

// File: tb/tb_bullet_hit_scheduler.sv
// Directed bench for bullet_hit_scheduler with default parameters (N_EB=8).
module tb_bullet_hit_scheduler;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        frame_tick = 1'b0;
    logic [9:0]  p_x = '0;
    logic [9:0]  p_y = '0;
    logic        my_en = 1'b0;
    logic [79:0] eb_x_flat;
    logic [79:0] eb_y_flat;
    logic [7:0]  eb_en = '0;
    logic [7:0]  eb_clr;
    logic [3:0]  present_health;
    logic        hit_pulse, boom, scan_busy, frame_overrun;

    logic [9:0]  ex [8];
    logic [9:0]  ey [8];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int tick_edge;
    int clr_cnt [8];
    int clr_cyc [8];
    int max_pop, hp_cnt, hp_cyc, busy_cnt, boom_cyc;
    logic boom_at_hp, boom_prev;

    bullet_hit_scheduler dut (
        .clk            (clk),
        .rst            (rst),
        .frame_tick     (frame_tick),
        .p_x            (p_x),
        .p_y            (p_y),
        .my_en          (my_en),
        .eb_x_flat      (eb_x_flat),
        .eb_y_flat      (eb_y_flat),
        .eb_en          (eb_en),
        .eb_clr         (eb_clr),
        .present_health (present_health),
        .hit_pulse      (hit_pulse),
        .boom           (boom),
        .scan_busy      (scan_busy),
        .frame_overrun  (frame_overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always_comb begin
        for (int i = 0; i < 8; i++) begin
            eb_x_flat[10*i +: 10] = ex[i];
            eb_y_flat[10*i +: 10] = ey[i];
        end
    end

    // Output monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (eb_clr != 8'd0) begin
            if ($countones(eb_clr) > max_pop) max_pop = $countones(eb_clr);
            for (int i = 0; i < 8; i++) begin
                if (eb_clr[i]) begin
                    clr_cnt[i] = clr_cnt[i] + 1;
                    clr_cyc[i] = cyc;
                end
            end
        end
        if (hit_pulse) begin
            hp_cnt     = hp_cnt + 1;
            hp_cyc     = cyc;
            boom_at_hp = boom;
        end
        if (scan_busy) busy_cnt = busy_cnt + 1;
        if (boom && !boom_prev) boom_cyc = cyc;
        boom_prev = boom;
    end

    task automatic clear_counts();
        for (int i = 0; i < 8; i++) begin
            clr_cnt[i] = 0;
            clr_cyc[i] = -1;
        end
        max_pop  = 0;
        hp_cnt   = 0;
        hp_cyc   = -1;
        busy_cnt = 0;
        boom_cyc = -1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst        = 1'b0;
        frame_tick = 1'b0;
        eb_en      = '0;
        my_en      = 1'b1;
        p_x        = 10'd100;
        p_y        = 10'd200;
        for (int i = 0; i < 8; i++) begin
            ex[i] = 10'd600;
            ey[i] = 10'd10;
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        clear_counts();
    endtask

    task automatic do_frame(input logic [7:0] en);
        @(negedge clk);
        eb_en = en;
        clear_counts();
        frame_tick = 1'b1;
        tick_edge  = cyc + 1;
        @(negedge clk);
        frame_tick = 1'b0;
        repeat (13) @(negedge clk);
    endtask

    task automatic idle_frames(input int n);
        repeat (n) do_frame(8'h00);
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        total++;
        if (present_health !== 4'd3) begin
            bad++; $display("FAIL reset_health: got %0d want 3", present_health);
        end
        total++;
        if ({eb_clr, hit_pulse, boom, scan_busy, frame_overrun} !== 12'd0) begin
            bad++; $display("FAIL reset_flags: clr=%h hp=%b boom=%b busy=%b ovr=%b want all 0",
                            eb_clr, hit_pulse, boom, scan_busy, frame_overrun);
        end
    endtask

    task automatic test_idle_frame();
        do_frame(8'h00);
        total++;
        if (present_health !== 4'd3) begin
            bad++; $display("FAIL idle_health: got %0d want 3", present_health);
        end
        total++;
        if (max_pop != 0 || hp_cnt != 0) begin
            bad++; $display("FAIL idle_events: clr_pop=%0d hp=%0d want 0 0", max_pop, hp_cnt);
        end
        total++;
        if (busy_cnt != 9) begin
            bad++; $display("FAIL idle_busy_len: got %0d want 9", busy_cnt);
        end
    endtask

    task automatic test_single_hit();
        do_reset();
        ex[3] = 10'd100;
        ey[3] = 10'd200;
        do_frame(8'h08);
        total++;
        if (clr_cnt[3] != 1 || max_pop != 1 || clr_cnt[0] != 0 || clr_cnt[7] != 0) begin
            bad++; $display("FAIL single_clr: slot3=%0d pop=%0d want 1 1", clr_cnt[3], max_pop);
        end
        total++;
        if (clr_cyc[3] - tick_edge != 4) begin
            bad++; $display("FAIL single_clr_time: got %0d want 4", clr_cyc[3] - tick_edge);
        end
        total++;
        if (hp_cnt != 1 || hp_cyc - tick_edge != 10) begin
            bad++; $display("FAIL single_hp: count=%0d lat=%0d want 1 10", hp_cnt,
                            hp_cyc - tick_edge);
        end
        total++;
        if (present_health !== 4'd2) begin
            bad++; $display("FAIL single_health: got %0d want 2", present_health);
        end
    endtask

    task automatic test_multi_hit();
        do_reset();
        ex[1] = 10'd95;  ey[1] = 10'd190;
        ex[5] = 10'd110; ey[5] = 10'd210;
        do_frame(8'h22);
        total++;
        if (clr_cnt[1] != 1 || clr_cnt[5] != 1 || max_pop != 1) begin
            bad++; $display("FAIL multi_clr: s1=%0d s5=%0d pop=%0d want 1 1 1",
                            clr_cnt[1], clr_cnt[5], max_pop);
        end
        total++;
        if (hp_cnt != 1 || present_health !== 4'd2) begin
            bad++; $display("FAIL multi_damage: hp=%0d health=%0d want 1 2", hp_cnt,
                            present_health);
        end
    endtask

    task automatic test_iframe();
        do_reset();
        ex[0] = 10'd100; ey[0] = 10'd200;
        do_frame(8'h01);
        idle_frames(4);
        do_frame(8'h01);
        total++;
        if (clr_cnt[0] != 1 || hp_cnt != 0 || present_health !== 4'd2) begin
            bad++; $display("FAIL iframe_block: clr=%0d hp=%0d health=%0d want 1 0 2",
                            clr_cnt[0], hp_cnt, present_health);
        end
        idle_frames(25);
        do_frame(8'h01);
        total++;
        if (hp_cnt != 1 || present_health !== 4'd1) begin
            bad++; $display("FAIL iframe_expire: hp=%0d health=%0d want 1 1", hp_cnt,
                            present_health);
        end
    endtask

    task automatic test_bounds();
        logic [9:0] pxs  [5] = '{10'd90, 10'd89, 10'd149, 10'd150, 10'd0};
        logic [9:0] exs  [5] = '{10'd100, 10'd100, 10'd100, 10'd100, 10'd5};
        int         want [5] = '{1, 0, 1, 0, 1};
        do_reset();
        ey[0] = 10'd200;
        for (int k = 0; k < 5; k++) begin
            p_x   = pxs[k];
            ex[0] = exs[k];
            do_frame(8'h01);
            total++;
            if (clr_cnt[0] != want[k]) begin
                bad++; $display("FAIL bound_px%0d_ex%0d: clr=%0d want %0d", pxs[k], exs[k],
                                clr_cnt[0], want[k]);
            end
        end
    endtask

    task automatic test_boom();
        do_reset();
        ex[0] = 10'd100; ey[0] = 10'd200;
        do_frame(8'h01);
        idle_frames(30);
        do_frame(8'h01);
        idle_frames(30);
        do_frame(8'h01);
        total++;
        if (present_health !== 4'd0 || hp_cnt != 1) begin
            bad++; $display("FAIL boom_health: health=%0d hp=%0d want 0 1", present_health,
                            hp_cnt);
        end
        total++;
        if (boom_at_hp !== 1'b0 || boom_cyc != hp_cyc + 1 || boom !== 1'b1) begin
            bad++; $display("FAIL boom_timing: at_hp=%b rise=%0d hp=%0d now=%b want 0 hp+1 1",
                            boom_at_hp, boom_cyc, hp_cyc, boom);
        end
        do_frame(8'h01);
        total++;
        if (clr_cnt[0] != 0 || hp_cnt != 0 || present_health !== 4'd0 || boom !== 1'b1) begin
            bad++; $display("FAIL dead_suppress: clr=%0d hp=%0d health=%0d boom=%b want 0 0 0 1",
                            clr_cnt[0], hp_cnt, present_health, boom);
        end
        do_reset();
        @(negedge clk);
        total++;
        if (present_health !== 4'd3 || boom !== 1'b0) begin
            bad++; $display("FAIL boom_reset: health=%0d boom=%b want 3 0", present_health, boom);
        end
    endtask

    task automatic test_overrun();
        do_reset();
        @(negedge clk);
        total++;
        if (frame_overrun !== 1'b0) begin
            bad++; $display("FAIL overrun_init: got %b want 0", frame_overrun);
        end
        clear_counts();
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        repeat (2) @(negedge clk);
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        total++;
        if (frame_overrun !== 1'b1) begin
            bad++; $display("FAIL overrun_set: got %b want 1", frame_overrun);
        end
        repeat (20) @(negedge clk);
        total++;
        if (busy_cnt != 9 || hp_cnt != 0) begin
            bad++; $display("FAIL overrun_ignored: busy=%0d hp=%0d want 9 0", busy_cnt, hp_cnt);
        end
        do_frame(8'h00);
        total++;
        if (frame_overrun !== 1'b1 || busy_cnt != 9) begin
            bad++; $display("FAIL overrun_sticky: ovr=%b busy=%0d want 1 9", frame_overrun,
                            busy_cnt);
        end
    endtask

    initial begin
        boom_prev = 1'b0;
        for (int i = 0; i < 8; i++) begin
            ex[i] = 10'd600;
            ey[i] = 10'd10;
        end
        clear_counts();
        test_reset();
        test_idle_frame();
        test_single_hit();
        test_multi_hit();
        test_iframe();
        test_bounds();
        test_boom();
        test_overrun();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bullet_hit_scheduler.md
Name: bullet_hit_scheduler

Overview:
- Frame-paced controller that time-multiplexes one registered hit-box comparator across N_EB enemy-bullet slots.
- Per frame: sequences the scan, clears every bullet that hits the player, and applies at most one damage per frame.
- Enforces an invulnerability window, owns player health, and raises the game-over (boom) flag.
- Sits between the enemy bullet pool, which owns positions and enables, and the player/display logic.

Parameters:
- N_EB, 8, number of enemy bullet slots (2..16)
- HP_INIT, 3, health loaded at reset (1..15)
- IFRAME_FRAMES, 30, frames of invulnerability after damage (1..255)
- X_LO, 10, hit window left extent: player x >= bullet x - X_LO
- X_HI, 50, hit window right extent: player x < bullet x + X_HI
- Y_LO, 50, hit window upper extent: player y >= bullet y - Y_LO
- Y_HI, 40, hit window lower extent: player y < bullet y + Y_HI

Ports:
- clk  in  1  system clock
- rst  in  1  reset
- frame_tick  in  1  one-cycle pulse per video frame
- p_x  in  10  player x
- p_y  in  10  player y
- my_en  in  1  player alive/visible
- eb_x_flat  in  10*N_EB  bullet x; slot i at [10i+9:10i]
- eb_y_flat  in  10*N_EB  bullet y; same packing
- eb_en  in  N_EB  bullet slot active
- eb_clr  out  N_EB  one-cycle clear pulse per hit slot
- present_health  out  4  current health
- hit_pulse  out  1  one-cycle pulse when damage is applied
- boom  out  1  game over; sticky until reset
- scan_busy  out  1  high from scan start to scan end
- frame_overrun  out  1  sticky: frame_tick arrived while busy

Interface:
- One clock, clk.
- Reset rst is synchronous and active-low.
- Positions and eb_en must be held stable from the accepted frame_tick until scan_busy falls.

Behaviour:
- Reset (rst=0 at a clk edge):
  - present_health=HP_INIT
  - eb_clr=0, hit_pulse=0, boom=0, scan_busy=0, frame_overrun=0
  - iframe counter=0, state=IDLE
  - Reset mid-scan aborts the scan; no clears or damage are issued.
- States: IDLE -> SCAN -> APPLY -> IDLE.
- IDLE:
  - frame_tick: latch p_x, p_y, my_en.
  - Decrement the iframe counter if nonzero.
  - Clear hit_any, set index=0, scan_busy=1, go to SCAN.
- SCAN:
  - Presents slot `index` to the comparator, one slot per cycle.
  - The comparator result is registered, so each slot's result appears one cycle after presentation.
  - The pipeline drains after index N_EB-1; SCAN lasts N_EB+1 cycles.
- Comparator arithmetic:
  - 11-bit unsigned, written to avoid underflow.
  - hit = (px + X_LO >= ex) && (px < ex + X_HI) && (py + Y_LO >= ey) && (py < ey + Y_HI)
- Per result with eb_en[i] && hit && my_en_latched && health != 0:
  - Pulse eb_clr[i] for exactly one cycle.
  - Set hit_any.
  - Multiple slots may clear in one frame, on distinct cycles.
  - Bullets are cleared even while the iframe counter is nonzero.
- APPLY, one cycle:
  - If hit_any and iframe == 0 and health != 0: health -= 1, hit_pulse=1, iframe=IFRAME_FRAMES.
  - Otherwise health is unchanged.
  - scan_busy=0 on exit.
- Health:
  - Saturates at 0; it never wraps.
  - Health 0 suppresses all further clears and damage.
- boom: registered; set the cycle after health becomes 0; held until reset.
- frame_tick while scan_busy=1: ignored, and frame_overrun is set (sticky).
- Frame latency: the accepted frame_tick reaches hit_pulse in N_EB+2 cycles.

Decomposition:
- Package bullet_pkg holds:
  - state enum {IDLE, SCAN, APPLY}
  - COORD_W=10 and CMP_W=11
  - default hit-window constants X_LO, X_HI, Y_LO, Y_HI
- Sub-module hit_box_cmp: registered single-stage comparator.
  - Inputs: px, py, ex, ey, valid_in.
  - Outputs: hit_q, valid_q, idx_q.
  - Reused later by the player-bullet/enemy judge.

Test Plan:
- Reset, then frame_tick, with no eb_en set -> health stays 3; no eb_clr, no hit_pulse; scan_busy is high for 9 cycles (N_EB=8).
- p=(100,200); slot 3 at (100,200) enabled; frame_tick -> eb_clr[3] pulses once; hit_pulse at tick+10 cycles; health 3->2.
- Slots 1 and 5 both overlapping; frame_tick -> eb_clr[1] and eb_clr[5] each pulse once on separate cycles; health decrements by 1 only.
- Hit in frame 0, hit again in frame 5 (IFRAME_FRAMES=30) -> second bullet cleared, no damage; a hit at frame 31 decrements health.
- Edge bounds, bullet at (100,200): px=90 hits, px=89 misses; px=149 hits, px=150 misses. ex=5 with px=0 hits (no underflow).
- Three spaced hits from HP_INIT=3 -> health reaches 0, boom=1 the next cycle; later overlaps produce no eb_clr; rst=0 restores health=3, boom=0.
- frame_tick pulsed during scan_busy -> tick ignored, frame_overrun=1 and held.
